instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction memory: owns the PC, drives the memory address, and captures returned 32-bit instructions.
- Buffers returned instructions with their PCs in a small queue feeding decode through a valid/ready handshake.
- Handles control-flow redirects from execute, including flushing buffered and in-flight instructions.

Parameters:
- RESET_PC, 0, PC fetched first after reset release.
- QUEUE_DEPTH, 2, instruction queue entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock; rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- o_IAddr  out  XLEN  byte address to instruction memory; always word aligned.
- o_IReq  out  1  fetch request valid.
- i_IAck  in  1  memory returns i_IData for o_IAddr this cycle; may rise in the same cycle as o_IReq.
- i_IData  in  32  instruction word, little-endian assembled by memory.
- o_Instr  out  32  instruction at queue head.
- o_InstrPC  out  XLEN  PC of o_Instr.
- o_InstrValid  out  1  queue not empty.
- i_DecodeReady  in  1  decode accepts head this cycle.
- i_Redirect  in  1  branch/jump taken; flush and refetch.
- i_RedirectPC  in  XLEN  redirect target.

Behaviour:
- Reset (async assert, sync release):
  - fetch PC = RESET_PC; queue empty; FSM = S_FETCH.
  - o_IReq = 0, o_InstrValid = 0, o_Instr = 0, o_InstrPC = 0, o_IAddr = RESET_PC.
- o_IAddr = fetch PC register. PC increments by 4 on each accepted ack; wraps modulo 2^XLEN.
- Request/ack rules:
  - While o_IReq = 1 and i_IAck = 0, o_IAddr and o_IReq hold stable.
  - Only one request outstanding at a time.
  - i_IAck while o_IReq = 0 is ignored.
- FSM states:
  - S_FETCH: o_IReq = 1 when queue count < QUEUE_DEPTH, otherwise 0.
    - On ack: push {fetch PC, i_IData}; PC += 4.
  - S_DISCARD: o_IReq = 1 at the stale address; data on ack is dropped.
    - On ack: go to S_FETCH at the redirect PC latched on entry.
- Handshake: pop occurs when o_InstrValid & i_DecodeReady. Push and pop in the same cycle keep count unchanged. Push never occurs at full.
- Latency: ack in cycle N gives o_InstrValid in cycle N+1 (registered queue). Sustained throughput is 1 instr/cycle with zero-wait memory and decode always ready.
- Redirect (highest priority, cycle R):
  - Queue flushed at edge R; any pop or push in cycle R is discarded. o_InstrValid = 0 in R+1.
  - If no request outstanding, or ack arrives in cycle R: fetch PC = i_RedirectPC[XLEN-1:2],2'b00; new request in R+1.
  - If request outstanding without ack: latch target, enter S_DISCARD.
  - Redirect while in S_DISCARD: overwrite the latched target.
- Queue full: o_IReq drops; it reasserts the cycle after a pop.
- Reset asserted mid-request: everything returns to reset values immediately; the pending ack is abandoned.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Extra output o_MisalignTrap (1 bit, reset 0) is set in R+1 when i_Redirect occurs with i_RedirectPC[1:0] != 0.
  - Fetching halts (o_IReq = 0) until the next aligned redirect or reset; that redirect clears o_MisalignTrap.
- Not defined: low two bits are silently cleared; no extra port.

Test Plan:
- Reset release with RESET_PC = 0, zero-wait memory, i_DecodeReady = 1 -> o_IAddr 0,4,8,... on consecutive cycles; o_InstrPC 0,4,8 one cycle behind; o_Instr matches memory words.
- i_DecodeReady = 0 for 5 cycles -> exactly QUEUE_DEPTH (2) entries captured, o_IReq = 0, o_IAddr holds 0x8; on ready, PCs 0x0, 0x4 drain in order with no loss or duplication.
- i_Redirect with i_RedirectPC = 0x100 while queue holds 2 entries -> o_InstrValid = 0 next cycle; the next o_InstrPC is 0x100; no stale PC appears.
- Memory with 3-cycle ack latency, redirect to 0x40 during an outstanding request at 0x10 -> o_IAddr stays 0x10 until ack; that data is dropped; next request is at 0x40.
- Redirect to 0x203 -> without macro, fetch from 0x200; with FETCH_MISALIGN_TRAP_EN, o_MisalignTrap = 1 and o_IReq = 0 until a redirect to 0x300 resumes fetch.
- i_rstn asserted mid-stream with 1 queued entry and a pending request -> all outputs reset within the same cycle; after release, first o_IAddr = RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding requests to instruction memory,
// and buffers returned words in a small queue toward decode. Optional: FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     QUEUE_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  output logic [XLEN-1:0] o_IAddr,
  output logic            o_IReq,
  input  logic            i_IAck,
  input  logic [31:0]     i_IData,
  output logic [31:0]     o_Instr,
  output logic [XLEN-1:0] o_InstrPC,
  output logic            o_InstrValid,
  input  logic            i_DecodeReady,
  input  logic            i_Redirect,
  input  logic [XLEN-1:0] i_RedirectPC
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            o_MisalignTrap
`endif
);

  localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_DISCARD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            run_q;
  logic [31:0]     instr_mem_q [QUEUE_DEPTH];
  logic [XLEN-1:0] pc_mem_q    [QUEUE_DEPTH];

  logic            ack;
  logic            outstanding;
  logic            push;
  logic            pop;
  logic            halted;
  logic [XLEN-1:0] redir_pc;

  assign ack         = o_IReq & i_IAck;
  assign outstanding = o_IReq & ~i_IAck;
  assign push        = ack & (state_q == S_FETCH) & ~i_Redirect;
  assign pop         = o_InstrValid & i_DecodeReady & ~i_Redirect;
  assign redir_pc    = i_RedirectPC & ~(XLEN'(3));

  // run_q keeps o_IReq low while reset is held and releases it one edge later
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (i_Redirect && outstanding) state_d = S_DISCARD;
      S_DISCARD: if (ack) state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    o_IReq = 1'b0;
    case (state_q)
      S_FETCH:   o_IReq = run_q && !halted && (count_q < CW'(QUEUE_DEPTH));
      S_DISCARD: o_IReq = 1'b1;
      default:   o_IReq = 1'b0;
    endcase
  end

  // A redirect with a request still in flight parks the target until the stale ack returns
  always_comb begin
    pc_d  = pc_q;
    tgt_d = tgt_q;
    if (i_Redirect) begin
      if (outstanding) tgt_d = redir_pc;
      else             pc_d  = redir_pc;
    end else if (ack) begin
      if (state_q == S_FETCH) pc_d = pc_q + XLEN'(4);
      else                    pc_d = tgt_q;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (i_Redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_q     <= RESET_PC;
      tgt_q    <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        instr_mem_q[wr_ptr_q] <= i_IData;
        pc_mem_q[wr_ptr_q]    <= pc_q;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;

  always_comb begin
    trap_d = trap_q;
    if (i_Redirect) trap_d = |i_RedirectPC[1:0];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) trap_q <= 1'b0;
    else         trap_q <= trap_d;
  end

  assign halted         = trap_q;
  assign o_MisalignTrap = trap_q;
`else
  assign halted = 1'b0;
`endif

  assign o_IAddr      = pc_q;
  assign o_InstrValid = (count_q != '0);
  assign o_Instr      = o_InstrValid ? instr_mem_q[rd_ptr_q] : '0;
  assign o_InstrPC    = o_InstrValid ? pc_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural memory of programmable ack latency.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        i_rstn = 1'b1;
  logic [31:0] o_IAddr;
  logic        o_IReq;
  logic        i_IAck;
  logic [31:0] i_IData;
  logic [31:0] o_Instr;
  logic [31:0] o_InstrPC;
  logic        o_InstrValid;
  logic        i_DecodeReady = 1'b0;
  logic        i_Redirect = 1'b0;
  logic [31:0] i_RedirectPC = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        o_MisalignTrap;
`endif

  int errors = 0;
  int checks = 0;
  int ack_lat = 0;
  int wait_cnt = 0;

  instruction_fetch_unit #(
    .XLEN(32),
    .RESET_PC(32'h0),
    .QUEUE_DEPTH(2)
  ) dut (
    .i_clk(clk),
    .i_rstn(i_rstn),
    .o_IAddr(o_IAddr),
    .o_IReq(o_IReq),
    .i_IAck(i_IAck),
    .i_IData(i_IData),
    .o_Instr(o_Instr),
    .o_InstrPC(o_InstrPC),
    .o_InstrValid(o_InstrValid),
    .i_DecodeReady(i_DecodeReady),
    .i_Redirect(i_Redirect),
    .i_RedirectPC(i_RedirectPC)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .o_MisalignTrap(o_MisalignTrap)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory: acks after ack_lat wait cycles, returns a word derived from the address
  always @(posedge clk) begin
    if (o_IReq && !i_IAck) wait_cnt <= wait_cnt + 1;
    else                   wait_cnt <= 0;
  end

  always_comb begin
    i_IAck  = o_IReq && (wait_cnt >= ack_lat);
    i_IData = mem_word(o_IAddr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    i_Redirect    = 1'b0;
    i_RedirectPC  = '0;
    i_DecodeReady = rdy;
    ack_lat       = 0;
    i_rstn        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    i_rstn = 1'b1;
    #2;
    i_rstn = 1'b0;
    repeat (2) tick();
    checks++; if (o_IReq !== 1'b0) begin errors++; $display("FAIL rst_ireq got=%b exp=0", o_IReq); end
    checks++; if (o_InstrValid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", o_InstrValid); end
    checks++; if (o_Instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", o_Instr); end
    checks++; if (o_InstrPC !== 32'h0) begin errors++; $display("FAIL rst_instrpc got=%h exp=0", o_InstrPC); end
    checks++; if (o_IAddr !== 32'h0) begin errors++; $display("FAIL rst_iaddr got=%h exp=0", o_IAddr); end
    i_rstn = 1'b1;
    tick();
    checks++; if (o_IReq !== 1'b1) begin errors++; $display("FAIL rst_release_ireq got=%b exp=1", o_IReq); end
    checks++; if (o_IAddr !== 32'h0) begin errors++; $display("FAIL rst_release_iaddr got=%h exp=0", o_IAddr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    checks++; if (o_IAddr !== 32'h0 || o_InstrValid !== 1'b0) begin errors++; $display("FAIL stream_start addr=%h valid=%b exp addr=0 valid=0", o_IAddr, o_InstrValid); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_pc = 32'(4 * (k - 1));
      checks++; if (o_IAddr !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, o_IAddr, 32'(4 * k)); end
      checks++; if (o_InstrValid !== 1'b1 || o_InstrPC !== exp_pc) begin errors++; $display("FAIL stream_pc k=%0d valid=%b got=%h exp=%h", k, o_InstrValid, o_InstrPC, exp_pc); end
      checks++; if (o_Instr !== mem_word(exp_pc)) begin errors++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, o_Instr, mem_word(exp_pc)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    repeat (6) tick();
    checks++; if (o_IReq !== 1'b0) begin errors++; $display("FAIL bp_ireq got=%b exp=0", o_IReq); end
    checks++; if (o_IAddr !== 32'h8) begin errors++; $display("FAIL bp_addr got=%h exp=8", o_IAddr); end
    checks++; if (o_InstrValid !== 1'b1 || o_InstrPC !== 32'h0) begin errors++; $display("FAIL bp_head valid=%b got=%h exp=0", o_InstrValid, o_InstrPC); end
    i_DecodeReady = 1'b1;
    tick();
    checks++; if (o_InstrPC !== 32'h4 || o_Instr !== mem_word(32'h4)) begin errors++; $display("FAIL bp_drain1 pc=%h instr=%h exp pc=4", o_InstrPC, o_Instr); end
    checks++; if (o_IReq !== 1'b1 || o_IAddr !== 32'h8) begin errors++; $display("FAIL bp_reissue ireq=%b addr=%h exp 1/8", o_IReq, o_IAddr); end
    tick();
    checks++; if (o_InstrPC !== 32'h8 || o_InstrValid !== 1'b1) begin errors++; $display("FAIL bp_drain2 pc=%h valid=%b exp pc=8", o_InstrPC, o_InstrValid); end
    checks++; if (o_IAddr !== 32'hC) begin errors++; $display("FAIL bp_addr2 got=%h exp=c", o_IAddr); end
  endtask

  task automatic test_redirect_flush();
    do_reset(1'b0);
    repeat (3) tick();
    checks++; if (o_InstrPC !== 32'h0 || o_IReq !== 1'b0) begin errors++; $display("FAIL fl_full pc=%h ireq=%b exp 0/0", o_InstrPC, o_IReq); end
    i_Redirect    = 1'b1;
    i_RedirectPC  = 32'h100;
    i_DecodeReady = 1'b1;
    tick();
    i_Redirect = 1'b0;
    checks++; if (o_InstrValid !== 1'b0) begin errors++; $display("FAIL fl_valid got=%b exp=0", o_InstrValid); end
    checks++; if (o_IAddr !== 32'h100 || o_IReq !== 1'b1) begin errors++; $display("FAIL fl_addr got=%h ireq=%b exp 100/1", o_IAddr, o_IReq); end
    tick();
    checks++; if (o_InstrPC !== 32'h100 || o_Instr !== mem_word(32'h100)) begin errors++; $display("FAIL fl_first pc=%h instr=%h exp pc=100", o_InstrPC, o_Instr); end
    tick();
    checks++; if (o_InstrPC !== 32'h104) begin errors++; $display("FAIL fl_second got=%h exp=104", o_InstrPC); end
  endtask

  task automatic test_discard();
    do_reset(1'b1);
    repeat (4) tick();
    checks++; if (o_IAddr !== 32'h10) begin errors++; $display("FAIL dc_setup got=%h exp=10", o_IAddr); end
    ack_lat      = 3;
    i_Redirect   = 1'b1;
    i_RedirectPC = 32'h40;
    tick();
    i_Redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_IAddr !== 32'h10 || o_IReq !== 1'b1 || o_InstrValid !== 1'b0) begin errors++; $display("FAIL dc_hold k=%0d addr=%h ireq=%b valid=%b exp 10/1/0", k, o_IAddr, o_IReq, o_InstrValid); end
      tick();
    end
    checks++; if (o_IAddr !== 32'h40 || o_InstrValid !== 1'b0) begin errors++; $display("FAIL dc_target addr=%h valid=%b exp 40/0", o_IAddr, o_InstrValid); end
    ack_lat = 0;
    tick();
    checks++; if (o_InstrPC !== 32'h40 || o_Instr !== mem_word(32'h40)) begin errors++; $display("FAIL dc_first pc=%h instr=%h exp pc=40", o_InstrPC, o_Instr); end
    ack_lat      = 3;
    i_Redirect   = 1'b1;
    i_RedirectPC = 32'h80;
    tick();
    i_RedirectPC = 32'h90;
    tick();
    i_Redirect = 1'b0;
    checks++; if (o_IAddr !== 32'h44 || o_IReq !== 1'b1) begin errors++; $display("FAIL dc_stale addr=%h ireq=%b exp 44/1", o_IAddr, o_IReq); end
    repeat (2) tick();
    checks++; if (o_IAddr !== 32'h90) begin errors++; $display("FAIL dc_retarget got=%h exp=90", o_IAddr); end
    ack_lat = 0;
  endtask

  task automatic test_misalign();
    do_reset(1'b1);
    i_Redirect   = 1'b1;
    i_RedirectPC = 32'h203;
    tick();
    i_Redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (o_MisalignTrap !== 1'b1 || o_IReq !== 1'b0) begin errors++; $display("FAIL ma_trap trap=%b ireq=%b exp 1/0", o_MisalignTrap, o_IReq); end
    tick();
    checks++; if (o_IReq !== 1'b0 || o_InstrValid !== 1'b0) begin errors++; $display("FAIL ma_halt ireq=%b valid=%b exp 0/0", o_IReq, o_InstrValid); end
    i_Redirect   = 1'b1;
    i_RedirectPC = 32'h300;
    tick();
    i_Redirect = 1'b0;
    checks++; if (o_MisalignTrap !== 1'b0 || o_IAddr !== 32'h300 || o_IReq !== 1'b1) begin errors++; $display("FAIL ma_resume trap=%b addr=%h ireq=%b exp 0/300/1", o_MisalignTrap, o_IAddr, o_IReq); end
`else
    checks++; if (o_IAddr !== 32'h200 || o_IReq !== 1'b1 || o_InstrValid !== 1'b0) begin errors++; $display("FAIL ma_align addr=%h ireq=%b valid=%b exp 200/1/0", o_IAddr, o_IReq, o_InstrValid); end
    tick();
    checks++; if (o_InstrPC !== 32'h200 || o_IAddr !== 32'h204) begin errors++; $display("FAIL ma_first pc=%h addr=%h exp 200/204", o_InstrPC, o_IAddr); end
`endif
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    i_Redirect   = 1'b1;
    i_RedirectPC = 32'hFFFF_FFFC;
    tick();
    i_Redirect = 1'b0;
    checks++; if (o_IAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", o_IAddr); end
    tick();
    checks++; if (o_IAddr !== 32'h0 || o_InstrPC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_next addr=%h pc=%h exp 0/fffffffc", o_IAddr, o_InstrPC); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    tick();
    ack_lat = 3;
    checks++; if (o_InstrValid !== 1'b1 || o_IReq !== 1'b1 || o_IAddr !== 32'h4) begin errors++; $display("FAIL rm_setup valid=%b ireq=%b addr=%h exp 1/1/4", o_InstrValid, o_IReq, o_IAddr); end
    #3;
    i_rstn = 1'b0;
    #1;
    checks++; if (o_IReq !== 1'b0 || o_InstrValid !== 1'b0) begin errors++; $display("FAIL rm_ctrl ireq=%b valid=%b exp 0/0", o_IReq, o_InstrValid); end
    checks++; if (o_IAddr !== 32'h0 || o_Instr !== 32'h0 || o_InstrPC !== 32'h0) begin errors++; $display("FAIL rm_data addr=%h instr=%h pc=%h exp 0/0/0", o_IAddr, o_Instr, o_InstrPC); end
    @(posedge clk);
    #1;
    i_rstn  = 1'b1;
    ack_lat = 0;
    tick();
    checks++; if (o_IAddr !== 32'h0 || o_IReq !== 1'b1 || o_InstrValid !== 1'b0) begin errors++; $display("FAIL rm_release addr=%h ireq=%b valid=%b exp 0/1/0", o_IAddr, o_IReq, o_InstrValid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_discard();
    test_misalign();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
